inject_port_arbiter: RTL and testbench
======================================

Name: inject_port_arbiter

Overview:
- Per-node scheduler in front of the six router injection ports (xpos, ypos, zpos, xneg, yneg, zneg) of each network_16 node.
- Shares those ports among NREQ local requesters, for example the collective engine, the host DMA and the reduce unit.
- Each requester presents one 85-bit packet and a target direction.
- The block arbitrates round-robin per port, registers the winner into a per-port output slot, and holds it until the router accepts it.

Parameters:
- NREQ, 4, number of requesters (2..8)
- PW, 85, packet width in bits; equals the router injection width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NREQ  per-requester packet valid
- req_dir  in  3*NREQ  per-requester direction, requester i at [3i+2:3i]; 0=xpos 1=ypos 2=zpos 3=xneg 4=yneg 5=zneg; 6,7 illegal
- req_hi  in  NREQ  priority hint; used only with INJ_PRIO_EN
- req_pkt  in  PW*NREQ  per-requester packet, requester i at [PW*i+PW-1:PW*i]
- req_ready  out  NREQ  requester i accepted this cycle
- port_ready  in  6  router accepts on port d this cycle (bit order = dir code)
- out_xpos_inject, out_ypos_inject, out_zpos_inject, out_xneg_inject, out_yneg_inject, out_zneg_inject  out  PW each  injection packet to router
- out_valid  out  6  slot d holds a packet
- err_illegal  out  1  one-cycle pulse, illegal dir accepted and dropped
- inj_count  out  16  packets delivered to the router, wraps at 65535->0

Behaviour:
- Reset (async): all slots empty; out_valid=0; all out_*_inject=0; req_ready=0; err_illegal=0; inj_count=0; all RR pointers=0. Reset mid-operation discards slot contents.
- Slot d can load when out_valid[d]==0, or when out_valid[d]==1 and port_ready[d]==1 (same-cycle drain and refill, full throughput).
- Candidates for port d: every i with req_valid[i] and req_dir[i]==d.
- Winner for port d: the first candidate at or after rr_ptr[d], searching upward modulo NREQ.
- On a grant: req_ready[winner]=1, combinational in the same cycle. The packet is in slot d from the next edge, so latency is 1 cycle from grant to out_valid.
- After a grant, rr_ptr[d] is set to winner+1 mod NREQ. With no grant, rr_ptr[d] holds.
- Ports arbitrate independently. Up to 6 grants per cycle, at most one per requester; a requester targets exactly one dir.
- Delivery: out_valid[d] && port_ready[d] at an edge. inj_count increments by the number of ports delivering that cycle (0..6).
- Drained slot with no refill: out_valid[d]=0 and out bus driven to 0.
- Held slot: packet and valid stay stable while port_ready[d]=0. The router may assert port_ready with no packet present; this has no effect.
- req_ready may depend combinationally on req_valid. Requesters must not depend combinationally on req_ready.
- Illegal dir (6 or 7):
  - Requester is accepted immediately: req_ready=1 and err_illegal=1 for that cycle; the packet is dropped.
  - If several are illegal, accept the lowest index only.
  - This does not affect any rr_ptr.
- Packet contents, including the opcode field, pass through unmodified.

Optional Feature:
- Macro INJ_PRIO_EN.
- Defined: for port d, if any candidate has req_hi set, only hi candidates compete (round-robin among them); rr_ptr updates as normal.
- Undefined: req_hi is ignored, pure round-robin. The port still exists and can be left unconnected.
- Hi requesters may starve lo ones; this is the intended behaviour.

Test Plan:
- Reset with requester 0 valid (dir 0, pkt 85'h1A5) -> out_valid=0 and outputs 0 while rst=1. After release: req_ready[0]=1 in the first cycle, out_xpos_inject=85'h1A5 and out_valid[0]=1 in the next cycle, inj_count=1 after one cycle with port_ready[0]=1.
- All 4 requesters hold valid on dir 2 (zpos), port_ready[2]=1 continuously -> grant order 0,1,2,3,0 on consecutive cycles, one packet per cycle on out_zpos_inject, inj_count +1 per cycle.
- Requesters 0..3 on dirs 0,1,3,5 simultaneously -> all four req_ready=1 in the same cycle; four out_valid bits set next cycle; inj_count +4 in the delivery cycle.
- port_ready[4]=0 for 5 cycles with a slot loaded and requester 1 waiting on dir 4 -> slot stable, req_ready[1]=0. When port_ready[4]=1: slot refills in the same edge with requester 1's packet.
- Requester 3 with dir 7 -> req_ready[3]=1 and err_illegal=1 for one cycle; no out_valid change; inj_count unchanged.
- INJ_PRIO_EN build: requesters 0 and 2 on dir 1, req_hi[2]=1 -> requester 2 wins every cycle. Clear req_hi[2] -> alternation resumes starting at requester 0, since rr_ptr[1]=3 wraps to 0.

Source files
------------

// File: rtl/inject_port_arbiter.sv
// Per-node injection scheduler: NREQ requesters share six router injection ports,
// round-robin per port, one registered slot per port. Optional macro: INJ_PRIO_EN.
module inject_port_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 85
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [3*NREQ-1:0]    req_dir,
  input  logic [NREQ-1:0]      req_hi,
  input  logic [PW*NREQ-1:0]   req_pkt,
  output logic [NREQ-1:0]      req_ready,
  input  logic [5:0]           port_ready,
  output logic [PW-1:0]        out_xpos_inject,
  output logic [PW-1:0]        out_ypos_inject,
  output logic [PW-1:0]        out_zpos_inject,
  output logic [PW-1:0]        out_xneg_inject,
  output logic [PW-1:0]        out_yneg_inject,
  output logic [PW-1:0]        out_zneg_inject,
  output logic [5:0]           out_valid,
  output logic                 err_illegal,
  output logic [15:0]          inj_count
);

  // Handshake: a requester holds req_valid/req_dir/req_pkt until it sees req_ready
  // high at a clock edge; req_ready is combinational and is the acceptance itself.

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTRW-1:0] rr_q   [6];
  logic [PTRW-1:0] rr_d   [6];
  logic [PW-1:0]   slot_q [6];
  logic [PW-1:0]   slot_d [6];
  logic [5:0]      vld_q, vld_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [NREQ-1:0] ready_c;
  logic            err_c;

`ifndef INJ_PRIO_EN
  logic unused_hi;
  assign unused_hi = ^req_hi;
`endif

  always_comb begin : arb
    logic [NREQ-1:0] cand;
    logic            found;
    logic [PTRW-1:0] win;
    logic [PTRW-1:0] idx;
    logic [PTRW:0]   sum;
    ready_c = '0;
    err_c   = 1'b0;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    cand    = '0;
    found   = 1'b0;
    win     = '0;
    idx     = '0;
    sum     = '0;
    for (int d = 0; d < 6; d++) begin
      slot_d[d] = slot_q[d];
      rr_d[d]   = rr_q[d];
    end

    // Illegal directions are swallowed, lowest index first, without touching any pointer.
    for (int i = 0; i < NREQ; i++) begin
      if (!err_c && req_valid[i] && (req_dir[3*i +: 3] >= 3'd6)) begin
        err_c      = 1'b1;
        ready_c[i] = 1'b1;
      end
    end

    for (int d = 0; d < 6; d++) begin
      for (int i = 0; i < NREQ; i++) begin
        cand[i] = req_valid[i] && (req_dir[3*i +: 3] == 3'(d));
      end
`ifdef INJ_PRIO_EN
      if (|(cand & req_hi)) cand = cand & req_hi;
`endif
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NREQ; k++) begin
        sum = {1'b0, rr_q[d]} + (PTRW+1)'(k);
        if (sum >= (PTRW+1)'(NREQ)) sum = sum - (PTRW+1)'(NREQ);
        idx = sum[PTRW-1:0];
        if (!found && cand[idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end

      if (vld_q[d] && port_ready[d]) begin
        vld_d[d]  = 1'b0;
        slot_d[d] = '0;
        cnt_d     = cnt_d + 16'd1;
      end
      // A draining slot may be refilled on the same edge.
      if (found && (!vld_q[d] || port_ready[d])) begin
        vld_d[d]     = 1'b1;
        slot_d[d]    = req_pkt[PW*win +: PW];
        ready_c[win] = 1'b1;
        rr_d[d]      = (win == PTRW'(NREQ-1)) ? '0 : win + PTRW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int d = 0; d < 6; d++) begin
        slot_q[d] <= '0;
        rr_q[d]   <= '0;
      end
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      for (int d = 0; d < 6; d++) begin
        slot_q[d] <= slot_d[d];
        rr_q[d]   <= rr_d[d];
      end
    end
  end

  assign req_ready       = rst ? '0 : ready_c;
  assign err_illegal     = !rst && err_c;
  assign out_valid       = vld_q;
  assign inj_count       = cnt_q;
  assign out_xpos_inject = slot_q[0];
  assign out_ypos_inject = slot_q[1];
  assign out_zpos_inject = slot_q[2];
  assign out_xneg_inject = slot_q[3];
  assign out_yneg_inject = slot_q[4];
  assign out_zneg_inject = slot_q[5];

endmodule

// File: tb/tb_inject_port_arbiter.sv
// Self-checking bench for inject_port_arbiter: directed scenarios plus randomized
// traffic checked against a per-port queue model.
module tb_inject_port_arbiter;
  localparam int NREQ = 4;
  localparam int PW   = 85;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [3*NREQ-1:0]   req_dir;
  logic [NREQ-1:0]     req_hi;
  logic [PW*NREQ-1:0]  req_pkt;
  logic [NREQ-1:0]     req_ready;
  logic [5:0]          port_ready;
  logic [PW-1:0]       o_xp, o_yp, o_zp, o_xn, o_yn, o_zn;
  logic [5:0]          out_valid;
  logic                err_illegal;
  logic [15:0]         inj_count;
  logic [PW-1:0]       out_bus [6];

  int n_cmp = 0;
  int n_mis = 0;
  logic [15:0] exp_cnt;

  // Scoreboard state for the random test.
  logic [PW-1:0] exp_q [6][$];
  int            m_rr  [6];
  logic [15:0]   m_cnt;

  inject_port_arbiter #(.NREQ(NREQ), .PW(PW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_dir(req_dir), .req_hi(req_hi),
    .req_pkt(req_pkt), .req_ready(req_ready), .port_ready(port_ready),
    .out_xpos_inject(o_xp), .out_ypos_inject(o_yp), .out_zpos_inject(o_zp),
    .out_xneg_inject(o_xn), .out_yneg_inject(o_yn), .out_zneg_inject(o_zn),
    .out_valid(out_valid), .err_illegal(err_illegal), .inj_count(inj_count)
  );

  assign out_bus[0] = o_xp;
  assign out_bus[1] = o_yp;
  assign out_bus[2] = o_zp;
  assign out_bus[3] = o_xn;
  assign out_bus[4] = o_yn;
  assign out_bus[5] = o_zn;

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic set_req(input int i, input logic v, input logic [2:0] dir,
                         input logic [PW-1:0] pkt, input logic hi);
    req_valid[i]        = v;
    req_dir[3*i +: 3]   = dir;
    req_pkt[PW*i +: PW] = pkt;
    req_hi[i]           = hi;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_dir   = '0;
    req_pkt   = '0;
    req_hi    = '0;
  endtask

  function automatic logic [PW-1:0] rand_pkt();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[PW-1:0];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    clear_reqs();
    port_ready = '0;
    set_req(0, 1'b1, 3'd0, 85'h1A5, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (out_valid !== 6'b0) begin n_mis++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_bus[0] !== '0) begin n_mis++; $display("FAIL reset_xpos: got %h want 0", out_bus[0]); end
    n_cmp++; if (req_ready !== 4'b0) begin n_mis++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_cmp++; if (inj_count !== 16'd0) begin n_mis++; $display("FAIL reset_inj_count: got %0d want 0", inj_count); end
    n_cmp++; if (err_illegal !== 1'b0) begin n_mis++; $display("FAIL reset_err: got %b want 0", err_illegal); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_mis++; $display("FAIL first_grant: got %b want 0001", req_ready); end
    @(negedge clk);
    clear_reqs();
    #1;
    n_cmp++; if (out_valid !== 6'b000001) begin n_mis++; $display("FAIL first_valid: got %b want 000001", out_valid); end
    n_cmp++; if (out_bus[0] !== 85'h1A5) begin n_mis++; $display("FAIL first_pkt: got %h want 1a5", out_bus[0]); end
    port_ready = 6'b000001;
    @(negedge clk);
    #1;
    exp_cnt = 16'd1;
    n_cmp++; if (inj_count !== exp_cnt) begin n_mis++; $display("FAIL first_count: got %0d want %0d", inj_count, exp_cnt); end
    n_cmp++; if (out_valid !== 6'b0) begin n_mis++; $display("FAIL first_drain_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_bus[0] !== '0) begin n_mis++; $display("FAIL first_drain_bus: got %h want 0", out_bus[0]); end
    port_ready = '0;
  endtask

  task automatic test_round_robin();
    logic [PW-1:0]   pk [4];
    logic [NREQ-1:0] e;
    for (int i = 0; i < 4; i++) begin
      pk[i] = rand_pkt();
      set_req(i, 1'b1, 3'd2, pk[i], 1'b0);
    end
    port_ready = 6'b000100;
    for (int k = 0; k < 5; k++) begin
      #1;
      e = NREQ'(1 << (k % 4));
      n_cmp++; if (req_ready !== e) begin n_mis++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, e); end
      n_cmp++; if (out_valid[2] !== (k > 0)) begin n_mis++; $display("FAIL rr_valid%0d: got %b want %b", k, out_valid[2], k > 0); end
      if (k > 0) begin
        n_cmp++; if (out_bus[2] !== pk[(k-1) % 4]) begin n_mis++; $display("FAIL rr_pkt%0d: got %h want %h", k, out_bus[2], pk[(k-1) % 4]); end
      end
      n_cmp++; if (inj_count !== exp_cnt) begin n_mis++; $display("FAIL rr_count%0d: got %0d want %0d", k, inj_count, exp_cnt); end
      @(negedge clk);
      if (k > 0) exp_cnt++;
    end
    clear_reqs();
    #1;
    n_cmp++; if (out_bus[2] !== pk[0]) begin n_mis++; $display("FAIL rr_last_pkt: got %h want %h", out_bus[2], pk[0]); end
    @(negedge clk);
    exp_cnt++;
    #1;
    n_cmp++; if (out_valid !== 6'b0) begin n_mis++; $display("FAIL rr_drained: got %b want 0", out_valid); end
    n_cmp++; if (inj_count !== exp_cnt) begin n_mis++; $display("FAIL rr_final_count: got %0d want %0d", inj_count, exp_cnt); end
    port_ready = '0;
  endtask

  task automatic test_parallel();
    logic [PW-1:0] pk [4];
    int dirs [4] = '{0, 1, 3, 5};
    for (int i = 0; i < 4; i++) begin
      pk[i] = rand_pkt();
      set_req(i, 1'b1, 3'(dirs[i]), pk[i], 1'b0);
    end
    #1;
    n_cmp++; if (req_ready !== 4'b1111) begin n_mis++; $display("FAIL par_grant: got %b want 1111", req_ready); end
    n_cmp++; if (err_illegal !== 1'b0) begin n_mis++; $display("FAIL par_err: got %b want 0", err_illegal); end
    @(negedge clk);
    clear_reqs();
    #1;
    n_cmp++; if (out_valid !== 6'b101011) begin n_mis++; $display("FAIL par_valid: got %b want 101011", out_valid); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_bus[dirs[i]] !== pk[i]) begin n_mis++; $display("FAIL par_pkt%0d: got %h want %h", i, out_bus[dirs[i]], pk[i]); end
    end
    port_ready = 6'b111111;
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd4;
    #1;
    n_cmp++; if (inj_count !== exp_cnt) begin n_mis++; $display("FAIL par_count: got %0d want %0d", inj_count, exp_cnt); end
    n_cmp++; if (out_valid !== 6'b0) begin n_mis++; $display("FAIL par_drained: got %b want 0", out_valid); end
    port_ready = '0;
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] pa, pb;
    pa = rand_pkt();
    pb = rand_pkt();
    set_req(0, 1'b1, 3'd4, pa, 1'b0);
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_mis++; $display("FAIL bp_grant0: got %b want 0001", req_ready); end
    @(negedge clk);
    clear_reqs();
    set_req(1, 1'b1, 3'd4, pb, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (req_ready !== 4'b0) begin n_mis++; $display("FAIL bp_hold_ready%0d: got %b want 0", k, req_ready); end
      n_cmp++; if (out_valid[4] !== 1'b1) begin n_mis++; $display("FAIL bp_hold_valid%0d: got %b want 1", k, out_valid[4]); end
      n_cmp++; if (out_bus[4] !== pa) begin n_mis++; $display("FAIL bp_hold_pkt%0d: got %h want %h", k, out_bus[4], pa); end
      @(negedge clk);
    end
    port_ready = 6'b010000;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_mis++; $display("FAIL bp_refill_grant: got %b want 0010", req_ready); end
    @(negedge clk);
    exp_cnt++;
    clear_reqs();
    #1;
    n_cmp++; if (out_bus[4] !== pb) begin n_mis++; $display("FAIL bp_refill_pkt: got %h want %h", out_bus[4], pb); end
    n_cmp++; if (out_valid !== 6'b010000) begin n_mis++; $display("FAIL bp_refill_valid: got %b want 010000", out_valid); end
    n_cmp++; if (inj_count !== exp_cnt) begin n_mis++; $display("FAIL bp_count: got %0d want %0d", inj_count, exp_cnt); end
    @(negedge clk);
    exp_cnt++;
    #1;
    n_cmp++; if (out_valid !== 6'b0) begin n_mis++; $display("FAIL bp_drained: got %b want 0", out_valid); end
    n_cmp++; if (inj_count !== exp_cnt) begin n_mis++; $display("FAIL bp_final_count: got %0d want %0d", inj_count, exp_cnt); end
    port_ready = '0;
  endtask

  task automatic test_illegal();
    logic [PW-1:0] pk;
    set_req(3, 1'b1, 3'd7, rand_pkt(), 1'b0);
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_mis++; $display("FAIL ill_ready: got %b want 1000", req_ready); end
    n_cmp++; if (err_illegal !== 1'b1) begin n_mis++; $display("FAIL ill_err: got %b want 1", err_illegal); end
    @(negedge clk);
    clear_reqs();
    #1;
    n_cmp++; if (err_illegal !== 1'b0) begin n_mis++; $display("FAIL ill_err_clear: got %b want 0", err_illegal); end
    n_cmp++; if (out_valid !== 6'b0) begin n_mis++; $display("FAIL ill_no_valid: got %b want 0", out_valid); end
    n_cmp++; if (inj_count !== exp_cnt) begin n_mis++; $display("FAIL ill_count: got %0d want %0d", inj_count, exp_cnt); end
    pk = rand_pkt();
    set_req(0, 1'b1, 3'd1, pk, 1'b0);
    set_req(2, 1'b1, 3'd6, rand_pkt(), 1'b0);
    set_req(3, 1'b1, 3'd7, rand_pkt(), 1'b0);
    #1;
    n_cmp++; if (req_ready !== 4'b0101) begin n_mis++; $display("FAIL ill_multi_ready: got %b want 0101", req_ready); end
    n_cmp++; if (err_illegal !== 1'b1) begin n_mis++; $display("FAIL ill_multi_err: got %b want 1", err_illegal); end
    @(negedge clk);
    clear_reqs();
    #1;
    n_cmp++; if (out_valid !== 6'b000010) begin n_mis++; $display("FAIL ill_multi_valid: got %b want 000010", out_valid); end
    n_cmp++; if (out_bus[1] !== pk) begin n_mis++; $display("FAIL ill_multi_pkt: got %h want %h", out_bus[1], pk); end
    port_ready = 6'b000010;
    @(negedge clk);
    exp_cnt++;
    #1;
    n_cmp++; if (inj_count !== exp_cnt) begin n_mis++; $display("FAIL ill_multi_count: got %0d want %0d", inj_count, exp_cnt); end
    port_ready = '0;
  endtask

`ifdef INJ_PRIO_EN
  task automatic test_prio();
    logic [NREQ-1:0] e;
    set_req(0, 1'b1, 3'd1, rand_pkt(), 1'b0);
    set_req(2, 1'b1, 3'd1, rand_pkt(), 1'b1);
    port_ready = 6'b000010;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) req_hi[2] = 1'b0;
      #1;
      e = (k < 3) ? 4'b0100 : ((k % 2 == 1) ? 4'b0001 : 4'b0100);
      n_cmp++; if (req_ready !== e) begin n_mis++; $display("FAIL prio_grant%0d: got %b want %b", k, req_ready, e); end
      @(negedge clk);
    end
    clear_reqs();
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd6;
    #1;
    n_cmp++; if (inj_count !== exp_cnt) begin n_mis++; $display("FAIL prio_count: got %0d want %0d", inj_count, exp_cnt); end
    port_ready = '0;
  endtask
`endif

  task automatic test_random(input int cycles);
    logic [NREQ-1:0] took, e_rdy, cand;
    logic            e_err;
    logic [PW-1:0]   e_bus;
    int              gwin [6];
    int              r, j;
    rst = 1'b1;
    clear_reqs();
    port_ready = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 6; d++) begin
      exp_q[d].delete();
      m_rr[d] = 0;
    end
    m_cnt = '0;
    took  = '0;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_valid[i] && !took[i])) begin
          r = $urandom_range(0, 23);
          set_req(i, ($urandom_range(0, 3) != 0), (r == 0) ? 3'd7 : (r == 1) ? 3'd6 : 3'(r % 6),
                  rand_pkt(), 1'($urandom_range(0, 1)));
        end
      end
      port_ready = 6'($urandom);
      #1;
      e_rdy = '0;
      e_err = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (!e_err && req_valid[i] && req_dir[3*i +: 3] >= 3'd6) begin
          e_err = 1'b1;
          e_rdy[i] = 1'b1;
        end
      end
      for (int d = 0; d < 6; d++) begin
        gwin[d] = -1;
        if (exp_q[d].size() == 0 || port_ready[d]) begin
          for (int i = 0; i < NREQ; i++) cand[i] = req_valid[i] && (req_dir[3*i +: 3] == 3'(d));
`ifdef INJ_PRIO_EN
          if ((cand & req_hi) != 0) cand = cand & req_hi;
`endif
          for (int k = 0; k < NREQ; k++) begin
            j = (m_rr[d] + k) % NREQ;
            if (gwin[d] < 0 && cand[j]) gwin[d] = j;
          end
          if (gwin[d] >= 0) e_rdy[gwin[d]] = 1'b1;
        end
      end
      n_cmp++; if (req_ready !== e_rdy) begin n_mis++; $display("FAIL rnd_ready c%0d: got %b want %b", c, req_ready, e_rdy); end
      n_cmp++; if (err_illegal !== e_err) begin n_mis++; $display("FAIL rnd_err c%0d: got %b want %b", c, err_illegal, e_err); end
      n_cmp++; if (inj_count !== m_cnt) begin n_mis++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, inj_count, m_cnt); end
      for (int d = 0; d < 6; d++) begin
        e_bus = (exp_q[d].size() != 0) ? exp_q[d][0] : '0;
        n_cmp++; if (out_valid[d] !== (exp_q[d].size() != 0)) begin n_mis++; $display("FAIL rnd_valid c%0d d%0d: got %b want %b", c, d, out_valid[d], exp_q[d].size() != 0); end
        n_cmp++; if (out_bus[d] !== e_bus) begin n_mis++; $display("FAIL rnd_pkt c%0d d%0d: got %h want %h", c, d, out_bus[d], e_bus); end
      end
      for (int d = 0; d < 6; d++) begin
        if (exp_q[d].size() != 0 && port_ready[d]) begin
          void'(exp_q[d].pop_front());
          m_cnt = m_cnt + 16'd1;
        end
        if (gwin[d] >= 0) begin
          exp_q[d].push_back(req_pkt[PW*gwin[d] +: PW]);
          m_rr[d] = (gwin[d] + 1) % NREQ;
        end
      end
      took = e_rdy;
      @(negedge clk);
    end
    clear_reqs();
    port_ready = '0;
  endtask

  initial begin
    rst = 1'b1;
    clear_reqs();
    port_ready = '0;
    exp_cnt = '0;
    test_reset();
    test_round_robin();
    test_parallel();
    test_backpressure();
    test_illegal();
`ifdef INJ_PRIO_EN
    test_prio();
`endif
    test_random(800);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
